// File: rtl/sigma_delta_adc_scheduler.sv
// sigma_delta_adc_scheduler
//
// Time-multiplexes one sigma-delta ADC front end across NUM_CH analog inputs
// through an external analog mux. Channels are visited round-robin from an
// enable mask. After every mux change the ADC is held in reset while the mux
// settles, the CIC warm-up samples are dropped, and then SAMPLES_PER_CH
// samples are forwarded with their channel number on a valid/ready stream.
//
// Ports:
//   clk        system clock, shared with the ADC instance
//   rst        synchronous active-high reset
//   enable     run the scheduler while high
//   ch_mask    per-channel enable, bit i = channel i
//   adc_rst    reset for the ADC instance
//   mux_sel    analog mux select
//   adc_output ADC sample
//   adc_valid  ADC sample strobe (one cycle wide)
//   out_data   forwarded sample
//   out_ch     channel that produced out_data
//   out_valid  out_data/out_ch valid
//   out_ready  consumer accepts when out_valid && out_ready
//   busy       high in every state except IDLE
//   overrun    sticky flag: a sample was dropped under backpressure

module sigma_delta_adc_scheduler #(
  parameter int NUM_CH            = 4,
  parameter int ADC_BITLEN        = 16,
  parameter int MUX_SETTLE_CYCLES = 64,
  parameter int DISCARD_SAMPLES   = 3,
  parameter int SAMPLES_PER_CH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_mask,
  output logic                      adc_rst,
  output logic [$clog2(NUM_CH)-1:0] mux_sel,
  input  logic [ADC_BITLEN-1:0]     adc_output,
  input  logic                      adc_valid,
  output logic [ADC_BITLEN-1:0]     out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      overrun
);

  localparam int CH_W       = $clog2(NUM_CH);
  localparam int SETTLE_W   = $clog2(MUX_SETTLE_CYCLES + 1);
  localparam int SAMPLE_MAX = (DISCARD_SAMPLES > SAMPLES_PER_CH) ? DISCARD_SAMPLES : SAMPLES_PER_CH;
  localparam int SAMPLE_W   = $clog2(SAMPLE_MAX + 1);

  // Terminal counts. DISCARD_LAST is unused when DISCARD_SAMPLES is 0
  // because SETTLE is then never entered.
  localparam logic [SETTLE_W-1:0] SETTLE_LAST  = SETTLE_W'(MUX_SETTLE_CYCLES - 1);
  localparam logic [SAMPLE_W-1:0] DISCARD_LAST = SAMPLE_W'(DISCARD_SAMPLES - 1);
  localparam logic [SAMPLE_W-1:0] VISIT_LAST   = SAMPLE_W'(SAMPLES_PER_CH - 1);

  typedef enum logic [2:0] {IDLE, SWITCH, SETTLE, CAPTURE, NEXT} state_t;

  state_t              state;
  state_t              state_next;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic [CH_W-1:0]     lowest_ch;
  logic [CH_W-1:0]     next_ch;
  logic [CH_W-1:0]     load_ch;
  logic                load_mux;
  logic                next_found;
  logic                settle_done;
  logic                discard_done;
  logic                visit_done;
  logic                capture_stb;
  logic                slot_free;

  // Channel index base+step, wrapping at NUM_CH (which need not be a power of two).
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int step);
    return CH_W'((int'(base) + step) % NUM_CH);
  endfunction

  assign settle_done  = (settle_cnt == SETTLE_LAST);
  assign discard_done = adc_valid && (sample_cnt == DISCARD_LAST);
  assign visit_done   = adc_valid && (sample_cnt == VISIT_LAST);
  assign capture_stb  = (state == CAPTURE) && adc_valid;
  assign slot_free    = !out_valid || out_ready;

  // Channel search: lowest set bit for a start from IDLE, and the next set bit
  // above mux_sel (wrapping) for NEXT. The wrap search ends on mux_sel itself,
  // so a single enabled channel selects itself again.
  always_comb begin
    lowest_ch  = '0;
    next_ch    = mux_sel;
    next_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[CH_W'(i)]) lowest_ch = CH_W'(i);
    end
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!next_found && ch_mask[wrap_add(mux_sel, i)]) begin
        next_found = 1'b1;
        next_ch    = wrap_add(mux_sel, i);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic, including when a new channel is loaded into the mux
  always_comb begin
    state_next = state;
    load_mux   = 1'b0;
    load_ch    = mux_sel;
    case (state)
      IDLE: begin
        if (enable && (ch_mask != '0)) begin
          state_next = SWITCH;
          load_mux   = 1'b1;
          load_ch    = lowest_ch;
        end
      end
      SWITCH: begin
        if (settle_done) state_next = (DISCARD_SAMPLES == 0) ? CAPTURE : SETTLE;
      end
      SETTLE: begin
        if (discard_done) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (visit_done) state_next = NEXT;
      end
      NEXT: begin
        if (!enable || (ch_mask == '0)) begin
          state_next = IDLE;
        end else if (next_ch != mux_sel) begin
          state_next = SWITCH;
          load_mux   = 1'b1;
          load_ch    = next_ch;
        end else begin
          // Same channel again: the ADC keeps running, so no settle or discard.
          state_next = CAPTURE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state
  always_comb begin
    adc_rst = (state == IDLE) || (state == SWITCH);
    busy    = (state != IDLE);
  end

  // Settle and sample counters clear on every state change; both stop at their
  // terminal count because the state always leaves on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      sample_cnt <= '0;
      mux_sel    <= '0;
    end else begin
      if (state_next != state) begin
        settle_cnt <= '0;
        sample_cnt <= '0;
      end else begin
        if ((state == SWITCH) && !settle_done)
          settle_cnt <= settle_cnt + 1'b1;
        if (((state == SETTLE) || (state == CAPTURE)) && adc_valid)
          sample_cnt <= sample_cnt + 1'b1;
      end
      if (load_mux) mux_sel <= load_ch;
    end
  end

  // Single-entry output register. A capture strobe loads it if the slot is
  // empty or being drained this cycle; otherwise the sample is lost and the
  // sticky overrun flag records it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (capture_stb && slot_free) begin
        out_data  <= adc_output;
        out_ch    <= mux_sel;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (capture_stb && !slot_free) overrun <= 1'b1;
    end
  end

endmodule
